// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends one byte
// framed as start/8 data/odd parity/stop on device clock edges, then checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StSend,
    StAck,
    StRelease
  } state_e;

  state_e          state;
  logic [2:0]      clk_sync;
  logic [2:0]      data_sync;
  logic [CntW-1:0] cnt;
  logic [3:0]      bit_idx;
  logic [9:0]      frame;
  logic            fall;
  logic            clk_s;
  logic            data_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[1:0], ps2_data_in};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign clk_s  = clk_sync[2];
  assign data_s = data_sync[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= StIdle;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        StIdle: begin
          if (tx_valid) begin
            // Shifted out LSB first: data[0..7], odd parity, stop.
            frame       <= {1'b1, ~^tx_data, tx_data};
            cnt         <= '0;
            bit_idx     <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (InhLast == '0);
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= StInhibit;
          end
        end

        StInhibit: begin
          if (cnt == InhLast) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            state       <= StSend;
          end else begin
            cnt         <= cnt + CntOne;
            ps2_data_oe <= ((cnt + CntOne) == InhLast);
          end
        end

        StSend: begin
          if (fall) begin
            cnt         <= '0;
            ps2_data_oe <= ~frame[0];
            frame       <= {1'b0, frame[9:1]};
            bit_idx     <= bit_idx + 4'd1;
            if (bit_idx == 4'd9) begin
              state <= StAck;
            end
          end else if (cnt == ToLast) begin
            err         <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= StIdle;
          end else begin
            cnt <= cnt + CntOne;
          end
        end

        StAck: begin
          if (fall) begin
            cnt <= '0;
            if (!data_s) begin
              state <= StRelease;
            end else begin
              err      <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= StIdle;
            end
          end else if (cnt == ToLast) begin
            err         <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= StIdle;
          end else begin
            cnt <= cnt + CntOne;
          end
        end

        StRelease: begin
          if (clk_s && data_s) begin
            done     <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= StIdle;
          end else if (fall) begin
            cnt <= '0;
          end else if (cnt == ToLast) begin
            err         <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= StIdle;
          end else begin
            cnt <= cnt + CntOne;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          cnt         <= '0;
          state       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device that clocks
// the frame, samples bits on rising edges and ACKs (or not); frames compared to a model.
module tb_ps2_host_tx;

  localparam int unsigned Inh = 8;
  localparam int unsigned Tmo = 100;
  // Device clock fall to host action: two synchroniser stages plus the registered update.
  localparam int SyncLat = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_bad = 0;
  int err_cyc = 0;
  logic [1:0] err_oe = 2'b00;
  logic       err_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
      err_oe  <= {ps2_clk_oe, ps2_data_oe};
      err_rdy <= tx_ready;
    end
    if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
    if (busy !== ~tx_ready) busy_bad <= busy_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic drive_bytes(input logic [7:0] b0, input logic [7:0] b1, input int n);
    int w;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b0;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (tx_ready !== 1'b1 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      check("accept_in_time", {31'd0, tx_ready}, 32'd1);
      @(negedge clk);
      if (i + 1 < n) tx_data = b1;
      else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
    end
  endtask

  // nfalls: number of device clock falls to generate; 11 includes the ACK phase.
  task automatic dev_txn(input int nfalls, input bit ack, output logic [10:0] bits,
                         output int inh_len, output int dfirst);
    int n;
    bits = '0;
    inh_len = 0;
    dfirst = -1;
    n = 0;
    @(negedge clk);
    while (ps2_clk_oe !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_seen", {31'd0, ps2_clk_oe}, 32'd1);
    while (ps2_clk_oe === 1'b1 && inh_len < 3000) begin
      if (ps2_data_oe === 1'b1 && dfirst < 0) dfirst = inh_len;
      inh_len++;
      // A device glitch during inhibit must be ignored by the host.
      if (inh_len == 3) dev_clk = 1'b0;
      if (inh_len == 4) dev_clk = 1'b1;
      @(negedge clk);
    end
    bits[0] = ps2_data_in;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 10 && k <= nfalls; k++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
      bits[k] = ps2_data_in;
      repeat (10) @(negedge clk);
    end
    if (nfalls > 10) begin
      if (ack) dev_data = 1'b0;
      repeat (2) @(negedge clk);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("return_to_idle", {31'd0, tx_ready}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic txn_checks(input string tag, input logic [7:0] b, input bit ack,
                            input logic [10:0] bits, input int inh, input int df,
                            input int d0, input int e0);
    check({tag, "_inhibit_len"}, inh, Inh);
    check({tag, "_data_oe_last_inhibit"}, df, Inh - 1);
    check({tag, "_frame"}, {21'd0, bits}, {21'd0, model_frame(b)});
    check({tag, "_done_pulses"}, done_cnt - d0, {31'd0, ack});
    check({tag, "_err_pulses"}, err_cnt - e0, {31'd0, !ack});
    check({tag, "_lines_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    if (!ack) begin
      check({tag, "_ready_after_err"}, {31'd0, err_rdy}, 32'd1);
      check({tag, "_oe_at_err"}, {30'd0, err_oe}, 32'd0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         par;
  } vec_t;

  initial begin : main
    vec_t       vecs[6];
    logic [10:0] bits, bits2;
    int         inh, df, inh2, df2, d0, e0;
    logic [7:0] b;
    bit         ack;

    vecs[0] = '{8'hED, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done_err", {30'd0, done, err}, 32'd0);
    check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      fork
        drive_bytes(vecs[i].data, 8'h00, 1);
        dev_txn(11, vecs[i].ack, bits, inh, df);
      join
      wait_idle();
      txn_checks("vec", vecs[i].data, vecs[i].ack, bits, inh, df, d0, e0);
      check("vec_parity_bit", {31'd0, bits[9]}, {31'd0, vecs[i].par});
    end

    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      d0  = done_cnt;
      e0  = err_cnt;
      fork
        drive_bytes(b, 8'h00, 1);
        dev_txn(11, ack, bits, inh, df);
      join
      wait_idle();
      txn_checks("rand", b, ack, bits, inh, df, d0, e0);
    end

    // Device stops after fall 4.
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      drive_bytes(8'hA5, 8'h00, 1);
      dev_txn(4, 1'b0, bits, inh, df);
    join
    wait_idle();
    check("tmo_partial_frame", {27'd0, bits[4:0]}, {27'd0, model_frame(8'hA5) & 11'h01F});
    check("tmo_err_latency", err_cyc - last_fall_cyc, SyncLat + Tmo);
    check("tmo_oe_at_err", {30'd0, err_oe}, 32'd0);
    check("tmo_done_pulses", done_cnt - d0, 32'd0);
    check("tmo_err_pulses", err_cnt - e0, 32'd1);

    // Reset in the middle of SEND, while the host is driving data low.
    fork
      drive_bytes(8'h5A, 8'h00, 1);
      dev_txn(3, 1'b0, bits, inh, df);
    join
    @(posedge clk);
    #2;
    check("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    resetn = 1'b0;
    #1;
    check("async_reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("async_reset_ready", {30'd0, tx_ready, busy}, 32'd2);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      drive_bytes(8'hF4, 8'h00, 1);
      dev_txn(11, 1'b1, bits, inh, df);
    join
    wait_idle();
    txn_checks("post_reset", 8'hF4, 1'b1, bits, inh, df, d0, e0);

    // Back-to-back with tx_valid held high across both bytes.
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      drive_bytes(8'hED, 8'h02, 2);
      begin
        dev_txn(11, 1'b1, bits, inh, df);
        dev_txn(11, 1'b1, bits2, inh2, df2);
      end
    join
    wait_idle();
    check("b2b_frame0", {21'd0, bits}, {21'd0, model_frame(8'hED)});
    check("b2b_frame1", {21'd0, bits2}, {21'd0, model_frame(8'h02)});
    check("b2b_inhibit1", inh2, Inh);
    check("b2b_done_pulses", done_cnt - d0, 32'd2);
    check("b2b_err_pulses", err_cnt - e0, 32'd0);

    check("done_err_overlap", both_cnt, 32'd0);
    check("busy_is_not_ready", busy_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
